// File: rtl/j_control.sv
// ---------------------------------------------------------------------------
// j_control
//
// Jump control for a simple pipelined datapath. It decides whether the
// instruction in decode redirects the PC, selects the next PC, and keeps a
// small amount of registered status about recent jumps.
//
// Ports:
//   clk        in   1  rising-edge clock for all state
//   rst_n      in   1  asynchronous active-low reset
//   jump       in   1  unconditional jump instruction decoded
//   jumpC      in   1  conditional jump instruction decoded
//   neq        in   1  condition select: 1 = jump-if-not-equal, 0 = jump-if-equal
//   zero       in   1  ALU zero flag: 1 = operands equal
//   pc_inc     in   8  sequential next PC (PC+1)
//   target     in   8  jump target address
//   saidaA     out  1  combinational jump-taken select
//   pc_next    out  8  combinational next PC
//   flush      out  1  registered flush, high the cycle after a taken jump
//   conflict   out  1  registered flag: jump and jumpC both high last cycle
//   taken_cnt  out  8  registered saturating count of taken jumps
// ---------------------------------------------------------------------------
module j_control (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       jump,
  input  logic       jumpC,
  input  logic       neq,
  input  logic       zero,
  input  logic [7:0] pc_inc,
  input  logic [7:0] target,
  output logic       saidaA,
  output logic [7:0] pc_next,
  output logic       flush,
  output logic       conflict,
  output logic [7:0] taken_cnt
);

  logic       taken;
  logic       flush_d;
  logic       flush_q;
  logic       conflict_d;
  logic       conflict_q;
  logic [7:0] taken_cnt_d;
  logic [7:0] taken_cnt_q;

  // Jump decision and PC select. The conditional branch is taken when the
  // equality result disagrees with the "not equal" select, i.e. neq XOR zero.
  // An unconditional jump wins over everything, including a simultaneous
  // conditional jump. This path is purely combinational and is deliberately
  // independent of reset so the PC mux keeps working while state is cleared.
  always_comb begin
    taken   = jump | (jumpC & (neq ^ zero));
    pc_next = taken ? target : pc_inc;
  end

  // Next-state values for the status registers. The flush follows the taken
  // decision by one cycle, so back-to-back jumps keep it high continuously.
  // The counter holds at 8'hFF instead of wrapping so a long run of jumps
  // still reads as "many" rather than collapsing back to zero.
  always_comb begin
    flush_d     = taken;
    conflict_d  = jump & jumpC;
    taken_cnt_d = taken_cnt_q;
    if (taken && (taken_cnt_q != 8'hFF)) begin
      taken_cnt_d = taken_cnt_q + 8'd1;
    end
  end

  // Status registers. Reset clears them immediately, including a pending
  // flush and a saturated count; the first update after release happens on
  // the first rising edge that sees rst_n high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_q     <= 1'b0;
      conflict_q  <= 1'b0;
      taken_cnt_q <= 8'h00;
    end else begin
      flush_q     <= flush_d;
      conflict_q  <= conflict_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

  assign saidaA    = taken;
  assign flush     = flush_q;
  assign conflict  = conflict_q;
  assign taken_cnt = taken_cnt_q;

endmodule

// File: tb/tb_j_control.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_j_control
//
// Directed bench for j_control. Inputs change on the falling clock edge and
// outputs are sampled either shortly after an input change (combinational
// paths) or on the following falling edge (registered paths).
// ---------------------------------------------------------------------------
module tb_j_control;

  logic       clk;
  logic       rst_n;
  logic       jump;
  logic       jumpC;
  logic       neq;
  logic       zero;
  logic [7:0] pc_inc;
  logic [7:0] target;
  logic       saidaA;
  logic [7:0] pc_next;
  logic       flush;
  logic       conflict;
  logic [7:0] taken_cnt;

  int vectors;
  int miscompares;

  logic [15:0] takenTable;

  j_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .jump      (jump),
    .jumpC     (jumpC),
    .neq       (neq),
    .zero      (zero),
    .pc_inc    (pc_inc),
    .target    (target),
    .saidaA    (saidaA),
    .pc_next   (pc_next),
    .flush     (flush),
    .conflict  (conflict),
    .taken_cnt (taken_cnt)
  );

  // 10 ns clock, first rising edge at 5 ns.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  // Drives the decode inputs and lets the combinational outputs settle.
  task automatic applyStimulus(input logic j, input logic jc, input logic n, input logic z);
    jump  = j;
    jumpC = jc;
    neq   = n;
    zero  = z;
    #1;
  endtask

  // Advances to the next falling edge, past exactly one rising edge.
  task automatic stepCycle();
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    // Expected saidaA indexed by {jump, jumpC, neq, zero}.
    takenTable  = 16'hFF60;

    rst_n  = 1'b0;
    pc_inc = 8'h11;
    target = 8'hA0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Reset values before any clock edge has occurred.
    #1;
    checkOutput("rst_flush", {7'd0, flush}, 8'h00);
    checkOutput("rst_conflict", {7'd0, conflict}, 8'h00);
    checkOutput("rst_cnt", taken_cnt, 8'h00);

    // Truth-table sweep while reset is held: combinational outputs follow the
    // inputs and the registers stay cleared.
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v;
      v = i[3:0];
      applyStimulus(v[3], v[2], v[1], v[0]);
      checkOutput($sformatf("tt_saidaA_%b", v), {7'd0, saidaA}, {7'd0, takenTable[i]});
      checkOutput($sformatf("tt_pc_next_%b", v), pc_next, takenTable[i] ? 8'hA0 : 8'h11);
    end
    stepCycle();
    checkOutput("rst_hold_cnt", taken_cnt, 8'h00);
    checkOutput("rst_hold_flush", {7'd0, flush}, 8'h00);

    // Release reset between edges with idle inputs.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("idle_flush", {7'd0, flush}, 8'h00);
    checkOutput("idle_cnt", taken_cnt, 8'h00);

    // Single unconditional jump then idle: flush pulses for one cycle.
    pc_inc = 8'h42;
    target = 8'h7C;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkOutput("jmp_saidaA", {7'd0, saidaA}, 8'h01);
    checkOutput("jmp_pc_next", pc_next, 8'h7C);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("idle_pc_next", pc_next, 8'h42);
    checkOutput("jmp_flush", {7'd0, flush}, 8'h01);
    checkOutput("jmp_cnt", taken_cnt, 8'h01);
    checkOutput("jmp_conflict", {7'd0, conflict}, 8'h00);
    stepCycle();
    checkOutput("jmp_flush_drop", {7'd0, flush}, 8'h00);
    checkOutput("jmp_cnt_hold", taken_cnt, 8'h01);

    // Conditional jump taken (bne, not equal), then not taken (bne, equal).
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
    checkOutput("bne_taken", {7'd0, saidaA}, 8'h01);
    stepCycle();
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkOutput("bne_not_taken", {7'd0, saidaA}, 8'h00);
    checkOutput("bne_not_taken_pc", pc_next, 8'h42);
    checkOutput("bne_flush", {7'd0, flush}, 8'h01);
    checkOutput("bne_cnt", taken_cnt, 8'h02);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("nt_flush", {7'd0, flush}, 8'h00);
    checkOutput("nt_cnt", taken_cnt, 8'h02);

    // Simultaneous jump and jumpC: conflict flagged, counted once.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("both_saidaA", {7'd0, saidaA}, 8'h01);
    stepCycle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("both_conflict", {7'd0, conflict}, 8'h01);
    checkOutput("both_cnt", taken_cnt, 8'h03);
    checkOutput("both_flush", {7'd0, flush}, 8'h01);
    stepCycle();
    checkOutput("both_conflict_drop", {7'd0, conflict}, 8'h00);

    // Back-to-back taken cycles keep flush high.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    stepCycle();
    checkOutput("b2b_flush_1", {7'd0, flush}, 8'h01);
    checkOutput("b2b_cnt_1", taken_cnt, 8'h04);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    stepCycle();
    checkOutput("b2b_flush_2", {7'd0, flush}, 8'h01);
    checkOutput("b2b_cnt_2", taken_cnt, 8'h05);

    // Asynchronous reset between edges with flush=1 and count=5; the
    // combinational select keeps working (beq with equal operands).
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_flush", {7'd0, flush}, 8'h00);
    checkOutput("async_cnt", taken_cnt, 8'h00);
    checkOutput("async_conflict", {7'd0, conflict}, 8'h00);
    checkOutput("async_saidaA", {7'd0, saidaA}, 8'h01);
    checkOutput("async_pc_next", pc_next, 8'h7C);

    // Release with a jump pending: first edge with rst_n high counts it.
    stepCycle();
    checkOutput("async_hold_cnt", taken_cnt, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    stepCycle();
    checkOutput("release_cnt", taken_cnt, 8'h01);
    checkOutput("release_flush", {7'd0, flush}, 8'h01);

    // Saturation: restart from reset and hold jump for 300 cycles.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 300; c++) begin
      stepCycle();
      if (c == 254) checkOutput("sat_254", taken_cnt, 8'hFE);
      if (c == 255) checkOutput("sat_255", taken_cnt, 8'hFF);
      if (c == 256) checkOutput("sat_256", taken_cnt, 8'hFF);
    end
    checkOutput("sat_300", taken_cnt, 8'hFF);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkOutput("sat_idle_cnt", taken_cnt, 8'hFF);
    checkOutput("sat_idle_flush", {7'd0, flush}, 8'h00);

    // Reset clears a saturated count immediately.
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("sat_reset_cnt", taken_cnt, 8'h00);
    rst_n = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/j_control.md
J_CONTROL -- requirements
Module: j_control

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset: clk is the single clock, rst_n is the reset, and all state elements are reset asynchronously when rst_n is low.
REQ-002 Port list (name  direction  width  meaning), in this order:
- clk  input  1  rising-edge clock for all state.
- rst_n  input  1  asynchronous active-low reset.
- jump  input  1  unconditional jump instruction decoded.
- jumpC  input  1  conditional jump instruction decoded.
- neq  input  1  condition select: 1 = jump-if-not-equal, 0 = jump-if-equal.
- zero  input  1  ALU zero flag: 1 = operands equal.
- pc_inc  input  8  sequential next PC (PC+1).
- target  input  8  jump target address.
- saidaA  output  1  combinational jump-taken select.
- pc_next  output  8  combinational next PC.
- flush  output  1  registered one-cycle pipeline flush.
- conflict  output  1  registered flag: jump and jumpC were both high in the previous cycle.
- taken_cnt  output  8  registered saturating count of taken jumps.
REQ-003 SHALL have no parameters; all widths are fixed as listed.

Function
REQ-004 saidaA SHALL equal jump OR (jumpC AND (neq XOR zero)), purely combinational, with zero cycles of latency.
REQ-005 Conditional cases:
- jumpC=1, neq=1, zero=0 gives saidaA=1.
- jumpC=1, neq=1, zero=1 gives saidaA=0.
- jumpC=1, neq=0, zero=1 gives saidaA=1.
- jumpC=1, neq=0, zero=0 gives saidaA=0.
REQ-006 jump=1 SHALL force saidaA=1 regardless of jumpC, neq and zero.
REQ-007 jump=0 and jumpC=0 SHALL give saidaA=0 regardless of neq and zero.
REQ-008 pc_next SHALL be combinational: target when saidaA=1, otherwise pc_inc.
REQ-009 flush SHALL be a register loaded with saidaA on every rising clk edge, so it is high for exactly the cycle after each taken cycle.
REQ-010 Back-to-back taken cycles SHALL hold flush high continuously.
REQ-011 conflict SHALL be a register loaded with (jump AND jumpC) on every rising clk edge.
REQ-012 Simultaneous jump and jumpC SHALL still be treated as taken under REQ-006 and SHALL update taken_cnt once.
REQ-013 On each rising edge with saidaA=1, taken_cnt SHALL increment by 1, saturating at 8'hFF with no wrap to 0.
REQ-014 Inputs with saidaA=0 SHALL leave taken_cnt unchanged.
REQ-015 Combinational outputs (saidaA, pc_next) SHALL depend only on current inputs and be unaffected by rst_n.

Reset
REQ-016 While rst_n=0:
- flush=0, conflict=0, taken_cnt=8'h00, applied immediately without waiting for a clock edge.
- saidaA and pc_next keep following REQ-004 and REQ-008.
REQ-017 Deassertion of rst_n SHALL take effect synchronously; the first update of registered outputs SHALL occur on the first rising clk edge with rst_n=1.
REQ-018 Assertion of rst_n mid-sequence SHALL clear all registered outputs, including a pending flush and a saturated taken_cnt.

Verification
REQ-019 Truth-table sweep: all 16 combinations of jump/jumpC/neq/zero with pc_inc=8'h11 and target=8'hA0 -> saidaA and pc_next match REQ-004 and REQ-008. Sample points:
- 0000 -> 0, 8'h11.
- 1000 -> 1, 8'hA0.
- 0110 -> 1.
- 0111 -> 0.
- 0100 -> 0.
- 0101 -> 1.
- 1111 -> 1.
REQ-020 Flush timing: one cycle of jump=1 followed by idle -> flush=1 for exactly one cycle after the jump cycle, then 0.
REQ-021 Conflict: jump=1 and jumpC=1 for one cycle -> next cycle conflict=1 and taken_cnt increased by exactly 1.
REQ-022 Saturation: jump=1 held for 300 cycles after reset -> taken_cnt reaches 8'hFF and stays at 8'hFF.
REQ-023 Asynchronous reset: pull rst_n low between clock edges while flush=1 and taken_cnt=8'h05 -> flush=0 and taken_cnt=8'h00 immediately; saidaA is unaffected.
